div_ctrl: RTL and testbench



---
 rtl/div_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_div_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Multi-cycle divide controller for the EX stage of the five-stage MIPS
// pipeline. It sequences a radix-2 restoring divider for DIV and DIVU. While a
// divide is in flight it asks the pipeline to hold, and it delivers
// {remainder, quotient} for the HI/LO write path.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   start_i    in   divide request from EX (level, held until result accepted)
//   signed_i   in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  in   dividend  [WIDTH-1:0]
//   opdata2_i  in   divisor   [WIDTH-1:0]
//   annul_i    in   cancel request (flush or exception)
//   result_o   out  {remainder, quotient} [2*WIDTH-1:0]; held between results
//   ready_o    out  one-cycle pulse while the result is valid
//   stall_o    out  pipeline hold request (combinational)
//
// Latency: a nonzero divisor gives ready_o WIDTH+1 cycles after the request
// is seen in FREE. A zero divisor gives ready_o 2 cycles after the request.
// -----------------------------------------------------------------------------
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working register, 2W+1 bits. The upper W+1 bits hold the partial
  // remainder. The lower bits start as the dividend magnitude and fill up
  // with quotient bits from the LSB.
  logic [2*WIDTH:0]   r_work;
  logic [WIDTH-1:0]   r_dvsr;      // |divisor|, latched on entry to ON
  logic               r_signed;    // latched signed_i
  logic               r_dvd_neg;   // dividend was negative (signed only)
  logic               r_dvs_neg;   // divisor was negative (signed only)
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;

  logic               w_start;
  logic               w_last;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH:0]   w_work_nxt;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_neg_quo;
  logic               w_neg_rem;

  // Magnitude of an operand. For signed operands with the MSB set this is
  // the two's-complement negation. The most negative value maps to itself,
  // which read as unsigned is exactly 2^(W-1).
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
    return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Conditional two's-complement negation, used for the sign correction.
  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign w_start = start_i & ~annul_i;
  assign w_last  = (r_cnt == CNT_LAST);

  // Restoring step. The partial remainder never exceeds 2*|divisor|-1, so
  // after a successful subtract the difference fits in W bits. A W-bit
  // modular subtract therefore gives the exact value whenever w_ge is set.
  assign w_ge   = (r_work[2*WIDTH:WIDTH] >= {1'b0, r_dvsr});
  assign w_diff = r_work[2*WIDTH-1:WIDTH] - r_dvsr;

  always_comb begin
    w_work_nxt = {r_work[2*WIDTH-1:0], 1'b0};
    if (w_ge) begin
      w_work_nxt = {w_diff, r_work[WIDTH-1:0], 1'b1};
    end
  end

  // Result extraction after the final iteration: quotient in the low W bits,
  // remainder one position above the midpoint. Sign correction follows the
  // truncating-division rules: the quotient sign is the XOR of the operand
  // signs, and the remainder takes the sign of the dividend.
  assign w_neg_quo = r_signed & (r_dvd_neg ^ r_dvs_neg);
  assign w_neg_rem = r_signed & r_dvd_neg;
  assign w_quo     = f_neg_if(w_work_nxt[WIDTH-1:0], w_neg_quo);
  assign w_rem     = f_neg_if(w_work_nxt[2*WIDTH:WIDTH+1], w_neg_rem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    ready_o     = 1'b0;

    // The hold drops in END so that EX can consume the result that cycle.
    stall_o = w_start & (r_state != S_END);
    ready_o = (r_state == S_END);

    case (r_state)
      S_FREE: begin
        if (w_start) begin
          w_state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        w_state_nxt = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt = S_FREE;
        end else if (w_last) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        // An annul here changes nothing: the result has already been produced.
        w_state_nxt = S_FREE;
      end
      default: begin
        w_state_nxt = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work    <= '0;
      r_dvsr    <= '0;
      r_signed  <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_FREE: begin
          // Latch everything now. The operands may change freely afterwards.
          if (w_start && (opdata2_i != '0)) begin
            r_work    <= {{WIDTH{1'b0}}, f_mag(opdata1_i, signed_i), 1'b0};
            r_dvsr    <= f_mag(opdata2_i, signed_i);
            r_signed  <= signed_i;
            r_dvd_neg <= signed_i & opdata1_i[WIDTH-1];
            r_dvs_neg <= signed_i & opdata2_i[WIDTH-1];
            r_cnt     <= '0;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            r_work <= w_work_nxt;
            r_cnt  <= r_cnt + CNT_ONE;
            if (w_last) begin
              r_result <= {w_rem, w_quo};
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            r_result <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sgn;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall;

  int n_run;
  int n_fail;

  logic [2*W-1:0] sb[$];

  div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .signed_i  (sgn),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .annul_i   (annul),
    .result_o  (result),
    .ready_o   (ready),
    .stall_o   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one divide at the beginning of a cycle (cycle 0) and hold the
  // request until ready_o. Checks stall every cycle, the ready latency, and
  // the scoreboard result. Then drops the request and checks that the pulse
  // has ended.
  task automatic run_div(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] exp, input int exp_lat);
    int cyc;
    bit done;
    logic [2*W-1:0] e;
    @(posedge clk); #1;
    start = 1'b1; sgn = s; op1 = a; op2 = b;
    sb.push_back(exp);
    cyc = 0;
    done = 0;
    while (!done && cyc <= 100) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        done = 1;
        n_run++;
        if (cyc != exp_lat) begin
          n_fail++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_run++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall_at_ready: got %b want 0", name, stall);
        end
        n_run++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s scoreboard_empty: got ready want no result", name);
        end else begin
          e = sb.pop_front();
          if (result !== e) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", name, result, e);
          end
        end
      end else begin
        n_run++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall cycle %0d: got %b want 1", name, cyc, stall);
        end
        cyc++;
      end
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL %s timeout: got no ready want ready at %0d", name, exp_lat);
      sb.delete();
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_run++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after: got %b want 0", name, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0; annul = 1'b0;
    #2;
    n_run++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result);
    end
    n_run++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_idle: got %b want 0", stall);
    end
    start = 1'b1;
    #1;
    n_run++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall_follows_start: got %b want 1", stall);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_run++;
      if (ready !== 1'b0 || result !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: got ready=%b result=%h want 0/0", ready, result);
      end
    end
  endtask

  task automatic test_unsigned();
    run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33);
  endtask

  task automatic test_signed();
    run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("sdiv_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
            {32'h0000_0000, 32'h8000_0000}, 33);
    run_div("udiv_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0,
            {32'h0000_FFFF, 32'h0000_FFFF}, 33);
  endtask

  task automatic test_byzero();
    run_div("div_by_zero", 32'd5, 32'd0, 1'b0, 64'd0, 2);
  endtask

  task automatic test_annul();
    run_div("annul_prep", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL annul_stall cycle %0d: got %b want 1", c, stall);
      end
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(negedge clk);
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL annul_stall_c10: got %b want 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    for (int c = 11; c <= 40; c++) begin
      @(negedge clk);
      if (c == 11) begin
        n_run++;
        if (stall !== 1'b0) begin
          n_fail++; $display("FAIL annul_stall_c11: got %b want 0", stall);
        end
      end
      n_run++;
      if (ready !== 1'b0 || result !== {32'd2, 32'd14}) begin
        n_fail++;
        $display("FAIL annul_hold cycle %0d: got ready=%b result=%h want 0/%h",
                 c, ready, result, {32'd2, 32'd14});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n_ready;
    int t_first;
    int t_second;
    logic [2*W-1:0] e;
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; op1 = 32'd9; op2 = 32'd2;
    sb.push_back({32'd1, 32'd4});
    cyc = 0; n_ready = 0; t_first = -1; t_second = -1;
    while (n_ready < 2 && cyc < 150) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        n_ready++;
        if (n_ready == 1) t_first = cyc;
        else t_second = cyc;
        n_run++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b scoreboard_empty: got ready want no result");
        end else begin
          e = sb.pop_front();
          if (result !== e) begin
            n_fail++; $display("FAIL b2b result %0d: got %h want %h", n_ready, result, e);
          end
        end
      end else begin
        n_run++;
        if (stall !== 1'b1) begin
          n_fail++; $display("FAIL b2b stall cycle %0d: got %b want 1", cyc, stall);
        end
      end
      @(posedge clk); #1;
      // Second instruction's operands appear while the first is still in ON.
      if (cyc == 4) begin
        op1 = 32'd20; op2 = 32'd6;
      end
      if (ready === 1'b0 && n_ready == 1 && t_first == cyc) begin
        sb.push_back({32'd2, 32'd3});
      end
      if (n_ready == 2) start = 1'b0;
      cyc++;
    end
    n_run++;
    if (n_ready != 2) begin
      n_fail++; $display("FAIL b2b timeout: got %0d pulses want 2", n_ready);
      sb.delete();
      start = 1'b0;
    end else if (t_second - t_first != 34) begin
      n_fail++; $display("FAIL b2b spacing: got %0d want 34", t_second - t_first);
    end
    @(negedge clk);
    n_run++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b ready_after: got %b want 0", ready);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
    sb.push_back({32'd2, 32'd14});
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    n_run++;
    if (result !== '0) begin
      n_fail++; $display("FAIL rstmid_result: got %h want 0", result);
    end
    n_run++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ready: got %b want 0", ready);
    end
    n_run++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_stall_start1: got %b want 1", stall);
    end
    start = 1'b0;
    #1;
    n_run++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_stall_start0: got %b want 0", stall);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_run++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_no_pulse: got %b want 0", ready);
      end
    end
    run_div("rstmid_fresh", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
